// File: rtl/pipeline_hazard_controller_pkg.sv
// rtl/pipeline_hazard_controller_pkg.sv - shared register/ALU types and hazard-controller pipeline types
package BasicTypes;
  typedef logic [4:0] RegAddr;
  typedef enum logic [1:0] {
    OP_TYPE_REG  = 2'b00,
    OP_TYPE_IMM  = 2'b01,
    OP_TYPE_PC   = 2'b10,
    OP_TYPE_ZERO = 2'b11
  } ALUOpType;
endpackage

package PipelineTypes;
  import BasicTypes::*;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEM     = 2'b01,
    FWD_WB      = 2'b10
  } FwdSel;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10
  } HazardState;

  typedef struct packed {
    logic   valid;
    logic   rdWrite;
    RegAddr rd;
    logic   isLoad;
  } InflightSlot;

  localparam InflightSlot EMPTY_SLOT = '0;

  function automatic logic srcMatch(input InflightSlot s, input RegAddr src, input logic used);
    return used && s.valid && s.rdWrite && (s.rd != '0) && (s.rd == src);
  endfunction

  // A matching load in EX cannot be forwarded; the load-use stall covers it.
  function automatic FwdSel pickFwd(input RegAddr src, input logic used,
                                    input InflightSlot ex, input InflightSlot mem);
    if (srcMatch(ex, src, used)) return ex.isLoad ? FWD_REGFILE : FWD_MEM;
    if (srcMatch(mem, src, used)) return FWD_WB;
    return FWD_REGFILE;
  endfunction
endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - Decode-stage instruction fields seen by the hazard controller
interface DecodeStageIF;
  import BasicTypes::*;
  logic     decValid;
  RegAddr   rs1Addr;
  RegAddr   rs2Addr;
  ALUOpType aluOp1Type;
  ALUOpType aluOp2Type;
  logic     isStore;
  logic     isLoad;
  RegAddr   rdAddr;
  logic     rdWrite;

  modport Controller (
    input decValid, rs1Addr, rs2Addr, aluOp1Type, aluOp2Type,
          isStore, isLoad, rdAddr, rdWrite
  );
endinterface

// File: rtl/pipeline_hazard_controller_scoreboard.sv
// rtl/pipeline_hazard_controller_scoreboard.sv - EX/MEM/WB in-flight destination slots
module inflight_scoreboard
  import PipelineTypes::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  InflightSlot entering,
  output InflightSlot exSlot,
  output InflightSlot memSlot,
  output InflightSlot wbSlot
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exSlot  <= EMPTY_SLOT;
      memSlot <= EMPTY_SLOT;
      wbSlot  <= EMPTY_SLOT;
    end else if (!hold) begin
      exSlot  <= entering;
      memSlot <= exSlot;
      wbSlot  <= memSlot;
    end
  end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - load-use stall, forwarding, flush and memory-freeze control
module pipeline_hazard_controller
  import BasicTypes::*;
  import PipelineTypes::*;
(
  input  logic              clk,
  input  logic              rst,
  DecodeStageIF.Controller  dec,
  input  logic              branchMispredict,
  input  logic              dmemBusy,
  output logic              stallFetch,
  output logic              stallDecode,
  output logic              bubbleExecute,
  output logic              flushDecode,
  output logic              freezeAll,
  output logic [1:0]        fwdSel1,
  output logic [1:0]        fwdSel2,
  output logic [31:0]       stallCount
);
  HazardState  state, nextState, resumeState, effState;
  InflightSlot exSlot, memSlot, wbSlot, entering;
  logic        use1, use2, loadUse, loadStall;
  logic        unusedSlotBits;

  inflight_scoreboard slots (
    .clk      (clk),
    .rst      (rst),
    .hold     (freezeAll),
    .entering (entering),
    .exSlot   (exSlot),
    .memSlot  (memSlot),
    .wbSlot   (wbSlot)
  );

  assign unusedSlotBits = ^{memSlot.isLoad, wbSlot};

  assign use1    = dec.decValid && (dec.aluOp1Type == OP_TYPE_REG);
  assign use2    = dec.decValid && ((dec.aluOp2Type == OP_TYPE_REG) || dec.isStore);
  assign loadUse = exSlot.isLoad &&
                   (srcMatch(exSlot, dec.rs1Addr, use1) || srcMatch(exSlot, dec.rs2Addr, use2));

  // MEM_WAIT is transparent once dmemBusy drops: that cycle behaves as the state it interrupted.
  assign effState = (state == MEM_WAIT) ? resumeState : state;

  // Outputs are gated by reset so they read idle while rst is held low.
  assign freezeAll     = rst && dmemBusy;
  assign flushDecode   = rst && !dmemBusy && branchMispredict;
  assign loadStall     = rst && !dmemBusy && !branchMispredict && loadUse && (effState == RUN);
  assign stallFetch    = loadStall;
  assign stallDecode   = loadStall;
  assign bubbleExecute = loadStall || flushDecode;

  always_comb begin
    fwdSel1 = FWD_REGFILE;
    fwdSel2 = FWD_REGFILE;
    if (rst && !bubbleExecute && dec.decValid) begin
      fwdSel1 = pickFwd(dec.rs1Addr, use1, exSlot, memSlot);
      fwdSel2 = pickFwd(dec.rs2Addr, use2, exSlot, memSlot);
    end
  end

  always_comb begin
    entering = EMPTY_SLOT;
    if (!bubbleExecute) begin
      entering = '{valid: dec.decValid, rdWrite: dec.rdWrite, rd: dec.rdAddr, isLoad: dec.isLoad};
    end
  end

  always_comb begin
    nextState = RUN;
    if (dmemBusy)                nextState = MEM_WAIT;
    else if (branchMispredict)   nextState = RUN;
    else if (loadStall)          nextState = LOAD_STALL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      resumeState <= RUN;
      stallCount  <= '0;
    end else begin
      state <= nextState;
      if (dmemBusy) resumeState <= effState;
      if ((stallDecode || freezeAll) && (stallCount != 32'hFFFF_FFFF)) begin
        stallCount <= stallCount + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed self-checking bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;
  import BasicTypes::*;
  import PipelineTypes::*;

  logic        clk;
  logic        rst;
  logic        branchMispredict;
  logic        dmemBusy;
  logic        stallFetch, stallDecode, bubbleExecute, flushDecode, freezeAll;
  logic [1:0]  fwdSel1, fwdSel2;
  logic [31:0] stallCount;
  int          checks;
  int          errors;

  DecodeStageIF decIf ();

  pipeline_hazard_controller dut (
    .clk              (clk),
    .rst              (rst),
    .dec              (decIf),
    .branchMispredict (branchMispredict),
    .dmemBusy         (dmemBusy),
    .stallFetch       (stallFetch),
    .stallDecode      (stallDecode),
    .bubbleExecute    (bubbleExecute),
    .flushDecode      (flushDecode),
    .freezeAll        (freezeAll),
    .fwdSel1          (fwdSel1),
    .fwdSel2          (fwdSel2),
    .stallCount       (stallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // expected order: {stallFetch, stallDecode, bubbleExecute, flushDecode, freezeAll}
  task automatic chkCtl(input string tag, input logic [4:0] exp);
    chk(tag, {27'b0, stallFetch, stallDecode, bubbleExecute, flushDecode, freezeAll}, {27'b0, exp});
  endtask

  task automatic chkFwd(input string tag, input logic [1:0] e1, input logic [1:0] e2);
    chk(tag, {28'b0, fwdSel1, fwdSel2}, {28'b0, e1, e2});
  endtask

  task automatic setDec(input logic v, input RegAddr r1, input ALUOpType t1, input RegAddr r2,
                        input ALUOpType t2, input logic st, input logic ld, input RegAddr rd,
                        input logic wr);
    decIf.decValid   = v;
    decIf.rs1Addr    = r1;
    decIf.aluOp1Type = t1;
    decIf.rs2Addr    = r2;
    decIf.aluOp2Type = t2;
    decIf.isStore    = st;
    decIf.isLoad     = ld;
    decIf.rdAddr     = rd;
    decIf.rdWrite    = wr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk = 0;
    rst = 0;
    branchMispredict = 1;
    dmemBusy = 1;
    setDec(1, 5'd5, OP_TYPE_REG, 5'd5, OP_TYPE_REG, 1, 1, 5'd5, 1);
    @(negedge clk);
    chkCtl("reset_ctl", 5'b00000);
    chkFwd("reset_fwd", 2'b00, 2'b00);
    chk("reset_count", stallCount, 32'd0);

    // lw x5 ; add x6,x5,x1
    step(); rst = 1; branchMispredict = 0; dmemBusy = 0;
    setDec(1, 5'd2, OP_TYPE_REG, 5'd0, OP_TYPE_IMM, 0, 1, 5'd5, 1);
    @(negedge clk);
    chkCtl("lw_issue_ctl", 5'b00000);
    step(); setDec(1, 5'd5, OP_TYPE_REG, 5'd1, OP_TYPE_REG, 0, 0, 5'd6, 1);
    @(negedge clk);
    chkCtl("lu_stall_ctl", 5'b11100);
    chkFwd("lu_stall_fwd", 2'b00, 2'b00);
    step();
    @(negedge clk);
    chkCtl("lu_after_ctl", 5'b00000);
    chkFwd("lu_after_fwd", 2'b10, 2'b00);
    chk("lu_count", stallCount, 32'd1);
    chk("lu_state", 32'(dut.state), 32'(LOAD_STALL));

    // add x5 ; sub x7,x5,x5
    step(); setDec(1, 5'd1, OP_TYPE_REG, 5'd2, OP_TYPE_REG, 0, 0, 5'd5, 1);
    step(); setDec(1, 5'd5, OP_TYPE_REG, 5'd5, OP_TYPE_REG, 0, 0, 5'd7, 1);
    @(negedge clk);
    chkCtl("ex_fwd_ctl", 5'b00000);
    chkFwd("ex_fwd", 2'b01, 2'b01);

    // add x5 ; nop ; sw x5,0(x2)
    step(); setDec(1, 5'd1, OP_TYPE_REG, 5'd2, OP_TYPE_REG, 0, 0, 5'd5, 1);
    step(); setDec(0, 5'd0, OP_TYPE_IMM, 5'd0, OP_TYPE_IMM, 0, 0, 5'd0, 0);
    step(); setDec(1, 5'd2, OP_TYPE_REG, 5'd5, OP_TYPE_IMM, 1, 0, 5'd0, 0);
    @(negedge clk);
    chkCtl("store_ctl", 5'b00000);
    chkFwd("store_fwd", 2'b00, 2'b10);

    // addi x0 ; add x3,x0,x0 ; lw x0 ; add x3,x0,x0
    step(); setDec(1, 5'd1, OP_TYPE_REG, 5'd0, OP_TYPE_IMM, 0, 0, 5'd0, 1);
    step(); setDec(1, 5'd0, OP_TYPE_REG, 5'd0, OP_TYPE_REG, 0, 0, 5'd3, 1);
    @(negedge clk);
    chkFwd("x0_fwd", 2'b00, 2'b00);
    step(); setDec(1, 5'd2, OP_TYPE_REG, 5'd0, OP_TYPE_IMM, 0, 1, 5'd0, 1);
    step(); setDec(1, 5'd0, OP_TYPE_REG, 5'd0, OP_TYPE_REG, 0, 0, 5'd3, 1);
    @(negedge clk);
    chkCtl("x0_load_ctl", 5'b00000);
    chkFwd("x0_load_fwd", 2'b00, 2'b00);

    // lw x8 ; add x9,x8,x8 with a redirect in the same cycle
    step(); setDec(1, 5'd2, OP_TYPE_REG, 5'd0, OP_TYPE_IMM, 0, 1, 5'd8, 1);
    step(); setDec(1, 5'd8, OP_TYPE_REG, 5'd8, OP_TYPE_REG, 0, 0, 5'd9, 1);
    branchMispredict = 1;
    @(negedge clk);
    chkCtl("br_lu_ctl", 5'b00110);
    chkFwd("br_lu_fwd", 2'b00, 2'b00);
    step(); branchMispredict = 0;
    setDec(0, 5'd8, OP_TYPE_REG, 5'd8, OP_TYPE_REG, 0, 0, 5'd9, 1);
    @(negedge clk);
    chk("br_state", 32'(dut.state), 32'(RUN));
    chkCtl("br_after_ctl", 5'b00000);
    chkFwd("invalid_dec_fwd", 2'b00, 2'b00);
    chk("br_count", stallCount, 32'd1);

    // reset while frozen on a pending load-use
    step(); setDec(1, 5'd2, OP_TYPE_REG, 5'd0, OP_TYPE_IMM, 0, 1, 5'd5, 1);
    step(); setDec(1, 5'd5, OP_TYPE_REG, 5'd1, OP_TYPE_REG, 0, 0, 5'd6, 1);
    dmemBusy = 1;
    @(negedge clk);
    chkCtl("frz_pre_rst", 5'b00001);
    #1 rst = 0;
    #1;
    chkCtl("rst_async_ctl", 5'b00000);
    chk("rst_async_count", stallCount, 32'd0);
    step(); rst = 1; dmemBusy = 0;
    @(negedge clk);
    chkCtl("post_rst_ctl", 5'b00000);
    chk("post_rst_state", 32'(dut.state), 32'(RUN));

    // memory busy for 3 cycles over a load-use, redirect ignored while frozen
    step(); setDec(1, 5'd2, OP_TYPE_REG, 5'd0, OP_TYPE_IMM, 0, 1, 5'd5, 1);
    step(); setDec(1, 5'd5, OP_TYPE_REG, 5'd1, OP_TYPE_REG, 0, 0, 5'd6, 1);
    dmemBusy = 1;
    @(negedge clk);
    chkCtl("frz1_ctl", 5'b00001);
    step(); branchMispredict = 1;
    @(negedge clk);
    chkCtl("frz2_br_ctl", 5'b00001);
    step(); branchMispredict = 0;
    @(negedge clk);
    chkCtl("frz3_ctl", 5'b00001);
    chk("frz3_count", stallCount, 32'd2);
    step(); dmemBusy = 0;
    @(negedge clk);
    chkCtl("frz_stall_ctl", 5'b11100);
    chk("frz_stall_count", stallCount, 32'd3);
    step();
    @(negedge clk);
    chkCtl("frz_done_ctl", 5'b00000);
    chkFwd("frz_done_fwd", 2'b10, 2'b00);
    chk("frz_done_count", stallCount, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
